// File: rtl/tiny_alu_if.sv
// rtl/tiny_alu_if.sv - command/result bundle between the tiny_alu driver and the tiny_alu core
//
// Purpose: groups the start handshake, opcode, operands, done pulse and result.
// Signals:
//   start_i  : command request, held high by the master until done_o is seen
//   opcode_i : 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 5-7 reserved
//   a_i, b_i : unsigned operands
//   done_o   : one-cycle completion pulse
//   result_o : double-width result, held between done pulses
// Modports: master drives the command and samples the response; slave is the core.

interface tiny_alu_if #(
    parameter int INPUT_DATA_BITS = 8,
    parameter int OPCODE_BITS     = 3
);
    logic                           start_i;
    logic [OPCODE_BITS-1:0]         opcode_i;
    logic [INPUT_DATA_BITS-1:0]     a_i;
    logic [INPUT_DATA_BITS-1:0]     b_i;
    logic                           done_o;
    logic [2*INPUT_DATA_BITS-1:0]   result_o;

    modport master (
        output start_i,
        output opcode_i,
        output a_i,
        output b_i,
        input  done_o,
        input  result_o
    );

    modport slave (
        input  start_i,
        input  opcode_i,
        input  a_i,
        input  b_i,
        output done_o,
        output result_o
    );
endinterface

// File: rtl/tiny_alu.sv
// rtl/tiny_alu.sv - tiny ALU core: add/and/xor in one cycle, multi-cycle multiply
//
// Purpose: captures one command per start handshake, executes it and returns a
// double-width result with a single-cycle done pulse. Re-arms only after start
// has been released.
// Ports:
//   clk_i : clock, all logic on the rising edge
//   rst_i : asynchronous active-high reset
//   alu   : tiny_alu_if slave (start_i, opcode_i, a_i, b_i in; done_o, result_o out)

module tiny_alu #(
    parameter int INPUT_DATA_BITS = 8,
    parameter int OPCODE_BITS     = 3,
    parameter int MUL_LATENCY     = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    tiny_alu_if.slave  alu
);
    localparam int W        = INPUT_DATA_BITS;
    localparam int RW       = 2 * INPUT_DATA_BITS;
    localparam int CNT_BITS = $clog2(MUL_LATENCY + 1);

    localparam logic [OPCODE_BITS-1:0] OP_ADD = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OP_AND = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] OP_XOR = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] OP_MUL = OPCODE_BITS'(4);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic [OPCODE_BITS-1:0]  opcode_q,  opcode_d;
    logic [W-1:0]            a_q,       a_d;
    logic [W-1:0]            b_q,       b_d;
    logic [CNT_BITS-1:0]     mul_cnt_q, mul_cnt_d;
    logic                    done_q,    done_d;
    logic [RW-1:0]           result_q,  result_d;

    logic [W:0]              sum_w;
    logic [RW-1:0]           exec_result;
    logic [RW-1:0]           product;

    // Single-cycle operations; no_op and reserved opcodes yield zero so the
    // handshake always completes.
    always_comb begin
        sum_w       = {1'b0, a_q} + {1'b0, b_q};
        exec_result = '0;
        case (opcode_q)
            OP_ADD:  exec_result = {{(W-1){1'b0}}, sum_w};
            OP_AND:  exec_result = {{W{1'b0}}, a_q & b_q};
            OP_XOR:  exec_result = {{W{1'b0}}, a_q ^ b_q};
            default: exec_result = '0;
        endcase
    end

    assign product = RW'(a_q) * RW'(b_q);

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        a_d       = a_q;
        b_d       = b_q;
        mul_cnt_d = mul_cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;   // done is a pulse: it drops on the edge after it rises

        case (state_q)
            IDLE: begin
                if (alu.start_i) begin
                    opcode_d = alu.opcode_i;
                    a_d      = alu.a_i;
                    b_d      = alu.b_i;
                    if (alu.opcode_i == OP_MUL) begin
                        state_d   = MUL;
                        mul_cnt_d = CNT_BITS'(1);
                    end else begin
                        state_d = EXEC;
                    end
                end
            end

            EXEC: begin
                result_d = exec_result;
                done_d   = 1'b1;
                state_d  = alu.start_i ? WAIT_LOW : IDLE;
            end

            // mul_cnt holds the number of edges since capture, so done lands
            // exactly MUL_LATENCY edges after the capture edge.
            MUL: begin
                if (mul_cnt_q == CNT_BITS'(MUL_LATENCY)) begin
                    result_d  = product;
                    done_d    = 1'b1;
                    mul_cnt_d = '0;
                    state_d   = alu.start_i ? WAIT_LOW : IDLE;
                end else begin
                    mul_cnt_d = mul_cnt_q + CNT_BITS'(1);
                end
            end

            // A held start never retriggers; wait for it to drop.
            WAIT_LOW: begin
                if (!alu.start_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mul_cnt_q <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mul_cnt_q <= mul_cnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign alu.done_o   = done_q;
    assign alu.result_o = result_q;
endmodule
